// File: rtl/keccak_zgen.sv
// keccak_zgen: fresh-randomness source for a masked Keccak chi S-box.
// One 31-bit x^31+x^28+1 LFSR per share pair, stepped 5 bits per delivered word.
module keccak_zgen #(
    parameter int SHARES          = 4,
    parameter int RESEED_INTERVAL = 1024,
    localparam int P              = (SHARES * SHARES - SHARES) / 2,
    localparam int ZW             = 5 * P
) (
    input  logic            ClkxCI,
    input  logic            RstxRI,
    input  logic [31*P-1:0] SeedxDI,
    input  logic            SeedValidxSI,
    output logic [ZW-1:0]   ZxDO,
    output logic            ZValidxSO,
    input  logic            ZReadyxSI,
    output logic            ExhaustedxSO
);

    typedef enum logic [1:0] {
        UNSEEDED,
        RUN,
        EXHAUSTED
    } state_t;

    localparam logic [15:0] LAST = 16'(RESEED_INTERVAL - 1);

    state_t      r_state;
    logic        r_zvalid;
    logic        r_exh;
    logic [15:0] r_cnt;
    logic        w_xfer;

    assign w_xfer       = r_zvalid & ZReadyxSI;
    assign ZValidxSO    = r_zvalid;
    assign ExhaustedxSO = r_exh;

    for (genvar p = 0; p < P; p++) begin : g_lane
        logic [30:0] r_lane;
        logic [30:0] w_seed;
        logic [30:0] w_load;
        logic [30:0] w_next;

        assign w_seed = SeedxDI[31*p +: 31];
        // An all-zero LFSR would lock up, so substitute the all-ones state.
        assign w_load = (w_seed == '0) ? 31'h7FFF_FFFF : w_seed;
        assign w_next = {r_lane[25:0],
                         r_lane[30] ^ r_lane[27],
                         r_lane[29] ^ r_lane[26],
                         r_lane[28] ^ r_lane[25],
                         r_lane[27] ^ r_lane[24],
                         r_lane[26] ^ r_lane[23]};

        always_ff @(posedge ClkxCI) begin
            if (RstxRI) begin
                r_lane <= '0;
            end else if (SeedValidxSI) begin
                r_lane <= w_load;
            end else if (w_xfer) begin
                r_lane <= w_next;
            end
        end

        assign ZxDO[5*p +: 5] = {r_lane[26], r_lane[27], r_lane[28],
                                 r_lane[29], r_lane[30]};
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            r_state  <= UNSEEDED;
            r_zvalid <= 1'b0;
            r_exh    <= 1'b0;
            r_cnt    <= '0;
        end else if (SeedValidxSI) begin
            r_state  <= RUN;
            r_zvalid <= 1'b1;
            r_exh    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt + 16'd1;
                        if (r_cnt == LAST) begin
                            r_state  <= EXHAUSTED;
                            r_zvalid <= 1'b0;
                            r_exh    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_zgen.sv
// tb_keccak_zgen: scoreboard bench for keccak_zgen.
// Stimulus pushes expected words; a negedge monitor pops them on every transfer.
module tb_keccak_zgen;

    localparam int SH = 4;
    localparam int P  = 6;
    localparam int ZW = 30;
    localparam int RI = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            sv;
    logic            rdy;
    logic [31*P-1:0] seed;
    logic [ZW-1:0]   z;
    logic            zv;
    logic            ex;

    always #5 clk = ~clk;

    keccak_zgen #(
        .SHARES(SH),
        .RESEED_INTERVAL(RI)
    ) dut (
        .ClkxCI(clk),
        .RstxRI(rst),
        .SeedxDI(seed),
        .SeedValidxSI(sv),
        .ZxDO(z),
        .ZValidxSO(zv),
        .ZReadyxSI(rdy),
        .ExhaustedxSO(ex)
    );

    int            nchk = 0;
    int            errs = 0;
    logic [ZW-1:0] sb[$];
    logic [30:0]   m_l[P];
    logic          m_v;
    logic          m_x;
    int            m_cnt;
    logic [ZW-1:0] hold;

    // Reference: five single-bit Fibonacci steps of x^31+x^28+1.
    function automatic logic [30:0] adv(input logic [30:0] l);
        logic [30:0] t;
        t = l;
        for (int i = 0; i < 5; i++) t = {t[29:0], t[30] ^ t[27]};
        return t;
    endfunction

    function automatic logic [ZW-1:0] zof();
        logic [ZW-1:0] r;
        r = '0;
        for (int p = 0; p < P; p++)
            for (int x = 0; x < 5; x++)
                r[5*p+x] = m_l[p][30-x];
        return r;
    endfunction

    task automatic chk(input string n, input logic [ZW-1:0] got,
                       input logic [ZW-1:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic load_seed(input logic [30:0] l0, input logic [30:0] rest);
        seed[30:0] = l0;
        for (int p = 1; p < P; p++) seed[31*p +: 31] = rest;
    endtask

    task automatic tick();
        logic xf;
        xf = m_v && rdy;
        if (xf) sb.push_back(zof());
        @(posedge clk);
        #1;
        if (rst) begin
            for (int p = 0; p < P; p++) m_l[p] = '0;
            m_v = 1'b0;
            m_x = 1'b0;
            m_cnt = 0;
        end else if (sv) begin
            for (int p = 0; p < P; p++)
                m_l[p] = (seed[31*p +: 31] == '0) ? 31'h7FFF_FFFF
                                                  : seed[31*p +: 31];
            m_v = 1'b1;
            m_x = 1'b0;
            m_cnt = 0;
        end else if (xf) begin
            for (int p = 0; p < P; p++) m_l[p] = adv(m_l[p]);
            m_cnt++;
            if (m_cnt == RI) begin
                m_v = 1'b0;
                m_x = 1'b1;
            end
        end
        chk("cyc_valid", ZW'(zv), ZW'(m_v));
        chk("cyc_exh", ZW'(ex), ZW'(m_x));
        chk("cyc_z", z, zof());
    endtask

    always @(negedge clk) begin
        if (zv && rdy) begin
            nchk++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL sb_unexpected got=%h exp=none", z);
            end else begin
                logic [ZW-1:0] e;
                e = sb.pop_front();
                if (z !== e) begin
                    errs++;
                    $display("FAIL sb_word got=%h exp=%h", z, e);
                end
            end
        end
    end

    initial begin
        for (int p = 0; p < P; p++) m_l[p] = '0;
        m_v = 1'b0;
        m_x = 1'b0;
        m_cnt = 0;
        seed = '0;
        rst = 1'b1;
        sv = 1'b1;
        rdy = 1'b0;
        load_seed(31'h0123_4567, 31'h0765_4321);
        tick();
        tick();
        chk("rst_z", z, '0);
        chk("rst_v", ZW'(zv), '0);
        rst = 1'b0;
        sv = 1'b0;
        tick();
        tick();
        chk("unseeded_v", ZW'(zv), '0);
        chk("unseeded_z", z, '0);

        load_seed(31'h4000_0000, 31'h7FFF_FFFF);
        sv = 1'b1;
        tick();
        sv = 1'b0;
        chk("seed_z", z, 30'h3FFF_FFE1);
        chk("seed_v", ZW'(zv), 30'd1);

        hold = z;
        repeat (10) begin
            tick();
            chk("bp_z", z, hold);
            chk("bp_v", ZW'(zv), 30'd1);
        end

        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("adv_z", z, 30'h3FFF_FFE0);

        rdy = 1'b1;
        repeat (3) tick();
        chk("exh_v", ZW'(zv), '0);
        chk("exh_x", ZW'(ex), 30'd1);
        tick();
        tick();
        chk("exh_hold_x", ZW'(ex), 30'd1);
        rdy = 1'b0;

        load_seed('0, '0);
        sv = 1'b1;
        tick();
        sv = 1'b0;
        chk("zero_z", z, '1);
        chk("zero_x", ZW'(ex), '0);
        chk("zero_v", ZW'(zv), 30'd1);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;

        load_seed(31'h2AAA_AAAA, 31'h2AAA_AAAA);
        sv = 1'b1;
        rdy = 1'b1;
        tick();
        sv = 1'b0;
        rdy = 1'b0;
        chk("coll_z", z, {6{5'b01010}});
        rdy = 1'b1;
        repeat (3) tick();
        rdy = 1'b0;
        chk("coll_cnt_v", ZW'(zv), 30'd1);

        rst = 1'b1;
        tick();
        chk("mrst_v", ZW'(zv), '0);
        chk("mrst_z", z, '0);
        rst = 1'b0;
        rdy = 1'b1;
        repeat (3) begin
            tick();
            chk("mrst_hold_z", z, '0);
        end
        rdy = 1'b0;

        load_seed(31'h0000_0001, 31'h5A5A_5A5A);
        sv = 1'b1;
        tick();
        sv = 1'b0;
        rdy = 1'b1;
        repeat (6) tick();
        rdy = 1'b0;
        chk("tput_x", ZW'(ex), 30'd1);
        tick();
        chk("sb_empty", ZW'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, errs);
        $finish;
    end

endmodule
